// File: rtl/register_file_write_arbiter_pkg.sv
// Shared widths, pointer-width helper and request record for register_file_write_arbiter.
// The optional address-collision check is enabled with REGFILE_ARB_CONFLICT_CHECK_EN.
package regfile_arb_pkg;

    localparam int N_BIT_DATA_DEF    = 32;
    localparam int N_BIT_ADDRESS_DEF = 16;
    localparam int N_WRITE_DEF       = 4;
    localparam int N_REQ_DEF         = 8;

    // Round-robin pointer width; never zero, even for a single requester.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [N_BIT_ADDRESS_DEF-1:0] address;
        logic [N_BIT_DATA_DEF-1:0]    data;
    } wr_req_t;

endpackage

// File: rtl/register_file_write_arbiter_rr_multi_grant_select.sv
// Combinational round-robin scan granting up to N_WRITE requesters per cycle.
// With REGFILE_ARB_CONFLICT_CHECK_EN defined, requesters colliding on an already granted address are skipped.
module rr_multi_grant_select
    import regfile_arb_pkg::*;
#(
    parameter int N_BIT_ADDRESS = N_BIT_ADDRESS_DEF,
    parameter int N_WRITE       = N_WRITE_DEF,
    parameter int N_REQ         = N_REQ_DEF,
    localparam int PTR_W        = ptr_width(N_REQ)
) (
    input  logic [PTR_W-1:0]                     rr_ptr,
    input  logic [N_REQ-1:0]                     valid,
    input  logic [N_REQ-1:0][N_BIT_ADDRESS-1:0]  address,
    output logic [N_REQ-1:0]                     grant,
    output logic [N_WRITE-1:0]                   port_valid,
    output logic [N_WRITE-1:0][PTR_W-1:0]        port_index,
    output logic [PTR_W-1:0]                     next_ptr
);

`ifdef REGFILE_ARB_CONFLICT_CHECK_EN
    localparam bit CONFLICT_CHECK = 1'b1;
`else
    localparam bit CONFLICT_CHECK = 1'b0;
`endif

    logic [N_WRITE-1:0][N_BIT_ADDRESS-1:0] port_address;

    always_comb begin
        int                     n_granted;
        int                     idx;
        logic                   cand_valid;
        logic [N_BIT_ADDRESS-1:0] cand_address;
        logic                   collide;

        grant        = '0;
        port_valid   = '0;
        port_index   = '0;
        port_address = '0;
        next_ptr     = rr_ptr;
        n_granted    = 0;
        idx          = 0;
        cand_valid   = 1'b0;
        cand_address = '0;
        collide      = 1'b0;

        for (int j = 0; j < N_REQ; j++) begin
            idx          = (int'(rr_ptr) + j) % N_REQ;
            cand_valid   = 1'b0;
            cand_address = '0;
            for (int i = 0; i < N_REQ; i++) begin
                if (i == idx) begin
                    cand_valid   = valid[i];
                    cand_address = address[i];
                end
            end

            // Only ports filled earlier in this same scan can collide.
            collide = 1'b0;
            for (int k = 0; k < N_WRITE; k++) begin
                if (CONFLICT_CHECK && port_valid[k] && port_address[k] == cand_address)
                    collide = 1'b1;
            end

            if (cand_valid && !collide && n_granted < N_WRITE) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (i == idx)
                        grant[i] = 1'b1;
                end
                for (int k = 0; k < N_WRITE; k++) begin
                    if (k == n_granted) begin
                        port_valid[k]   = 1'b1;
                        port_index[k]   = PTR_W'(idx);
                        port_address[k] = cand_address;
                    end
                end
                n_granted = n_granted + 1;
                next_ptr  = PTR_W'((idx + 1) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/register_file_write_arbiter.sv
// Shares N_WRITE register-file write ports among N_REQ requesters with registered port outputs.
// Define REGFILE_ARB_CONFLICT_CHECK_EN to keep same-address writes off parallel ports in one cycle.
module register_file_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int N_BIT_DATA    = N_BIT_DATA_DEF,
    parameter int N_BIT_ADDRESS = N_BIT_ADDRESS_DEF,
    parameter int N_WRITE       = N_WRITE_DEF,
    parameter int N_REQ         = N_REQ_DEF
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic                                  pause,
    input  logic [N_REQ-1:0]                      req_valid,
    input  logic [N_REQ-1:0][N_BIT_ADDRESS-1:0]   req_address,
    input  logic [N_REQ-1:0][N_BIT_DATA-1:0]      req_data,
    output logic [N_REQ-1:0]                      req_ready,
    output logic [N_WRITE-1:0]                    write,
    output logic [N_WRITE-1:0][N_BIT_ADDRESS-1:0] address_write,
    output logic [N_WRITE-1:0][N_BIT_DATA-1:0]    data_in
);

    localparam int PTR_W = ptr_width(N_REQ);

    logic [PTR_W-1:0]              rr_ptr;
    logic [PTR_W-1:0]              next_ptr_p0;
    logic [N_REQ-1:0]              vld_p0;
    logic [N_REQ-1:0]              grant_p0;
    logic [N_WRITE-1:0]            port_valid_p0;
    logic [N_WRITE-1:0][PTR_W-1:0] port_index_p0;

    // Reset and pause both suppress every grant, so the scan sees nothing valid.
    assign vld_p0 = (reset_n && !pause) ? req_valid : '0;

    rr_multi_grant_select #(
        .N_BIT_ADDRESS (N_BIT_ADDRESS),
        .N_WRITE       (N_WRITE),
        .N_REQ         (N_REQ)
    ) u_select (
        .rr_ptr     (rr_ptr),
        .valid      (vld_p0),
        .address    (req_address),
        .grant      (grant_p0),
        .port_valid (port_valid_p0),
        .port_index (port_index_p0),
        .next_ptr   (next_ptr_p0)
    );

    assign req_ready = grant_p0;

    // Stage p0 -> p1: granted requests land on the write-port registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rr_ptr        <= '0;
            write         <= '0;
            address_write <= '0;
            data_in       <= '0;
        end else begin
            rr_ptr <= next_ptr_p0;
            for (int k = 0; k < N_WRITE; k++) begin
                write[k] <= port_valid_p0[k];
                if (port_valid_p0[k]) begin
                    address_write[k] <= req_address[port_index_p0[k]];
                    data_in[k]       <= req_data[port_index_p0[k]];
                end
            end
        end
    end

endmodule
